// File: rtl/memory_unit.sv
// memory_unit: word-addressed data memory behind the command_processor memory port.
// Each CPU request completes a fixed LATENCY after it is accepted and ends with a
// one-cycle mem_response pulse. A loader port may write the array while the unit is idle.
module memory_unit #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_block,
  input  logic                  mem_mode,
  input  logic [15:0]           mem_locator,
  input  logic [DATA_WIDTH-1:0] mem_write,
  output logic [DATA_WIDTH-1:0] mem_read,
  output logic                  mem_response,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  busy,
  output logic                  addr_fault
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  block_q;
  logic                  pending_q, pending_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  mode_q;
  logic                  oor_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  accept;
  logic                  do_access;
  logic                  locator_oor;

  // Storage has no reset so that preloaded contents survive a CPU reset.
  logic [DATA_WIDTH-1:0] mem_q [Depth];

  // Any set bit above the array's address range makes the access out of range.
  assign locator_oor = (mem_locator >> ADDR_WIDTH) != '0;

  // A rise on mem_block is remembered until the FSM accepts it, so it is never lost.
  assign pending_d = (mem_block & ~block_q) | (pending_q & ~accept);

  // Next-state logic: accept in IDLE unless the loader owns this cycle, then count down.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    do_access = 1'b0;
    case (state_q)
      StIdle: begin
        if (pending_q && !load_en) begin
          accept  = 1'b1;
          cnt_d   = 4'(LATENCY - 1);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          do_access = 1'b1;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control state, request capture and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      block_q      <= 1'b0;
      pending_q    <= 1'b0;
      addr_q       <= '0;
      mode_q       <= 1'b0;
      oor_q        <= 1'b0;
      wdata_q      <= '0;
      mem_read     <= '0;
      mem_response <= 1'b0;
      busy         <= 1'b0;
      addr_fault   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      block_q   <= mem_block;
      pending_q <= pending_d;
      if (accept) begin
        addr_q  <= mem_locator[ADDR_WIDTH-1:0];
        mode_q  <= mem_mode;
        oor_q   <= locator_oor;
        wdata_q <= mem_write;
      end
      if (do_access) begin
        if (!mode_q) begin
          mem_read <= oor_q ? '0 : mem_q[addr_q];
        end
        if (oor_q) begin
          addr_fault <= 1'b1;
        end
      end
      mem_response <= do_access;
      busy         <= (state_d != StIdle);
    end
  end

  // Array writes: CPU write at the access edge, loader writes only while idle.
  always_ff @(posedge clk) begin
    if (do_access && mode_q && !oor_q) begin
      mem_q[addr_q] <= wdata_q;
    end else if ((state_q == StIdle) && load_en) begin
      mem_q[load_addr] <= load_data;
    end
  end

endmodule

// File: tb/tb_memory_unit.sv
// tb_memory_unit: scoreboard bench for memory_unit with a word-array reference model.
module tb_memory_unit;

  typedef struct packed {
    logic [15:0] data;
    logic        fault;
  } exp_t;

  logic        clk;
  logic        rst_n = 1'b1;
  logic        mem_block, mem_mode, load_en;
  logic [15:0] mem_locator, mem_write, load_data;
  logic [7:0]  load_addr;
  logic [15:0] mem_read, mem_read1;
  logic        mem_response, busy, addr_fault;
  logic        resp1, busy1, fault1;

  int vectors = 0;
  int miscompares = 0;

  exp_t        sb_q[$];
  logic [15:0] ref_mem [256];
  logic        ref_fault = 1'b0;
  logic [15:0] last_read = 16'h0;
  logic        prev_resp = 1'b0;

  memory_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .mem_block(mem_block), .mem_mode(mem_mode),
    .mem_locator(mem_locator), .mem_write(mem_write), .mem_read(mem_read),
    .mem_response(mem_response), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .busy(busy), .addr_fault(addr_fault)
  );

  // Second instance shares the stimulus; only its response timing is examined.
  memory_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .LATENCY(1)) dut_lat1 (
    .clk(clk), .rst_n(rst_n), .mem_block(mem_block), .mem_mode(mem_mode),
    .mem_locator(mem_locator), .mem_write(mem_write), .mem_read(mem_read1),
    .mem_response(resp1), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .busy(busy1), .addr_fault(fault1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  // Reference model: apply one CPU access and queue what the DUT must show on completion.
  task automatic model_op(input logic wr, input logic [15:0] loc, input logic [15:0] data);
    exp_t e;
    logic oor;
    oor = (loc >= 16'd256);
    if (wr) begin
      if (!oor) ref_mem[loc[7:0]] = data;
    end else begin
      last_read = oor ? 16'h0000 : ref_mem[loc[7:0]];
    end
    ref_fault = ref_fault | oor;
    e.data  = last_read;
    e.fault = ref_fault;
    sb_q.push_back(e);
  endtask

  // Monitor: every response pulse is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_resp = 1'b0;
    end else begin
      if (prev_resp) check("resp_width", {31'd0, mem_response}, 32'd0);
      if (mem_response) begin
        check("sb_depth", sb_q.size(), 32'd1);
        if (sb_q.size() > 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check("read_data", {16'd0, mem_read}, {16'd0, e.data});
          check("addr_fault", {31'd0, addr_fault}, {31'd0, e.fault});
        end
      end
      prev_resp = mem_response;
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_load(input logic [7:0] a, input logic [15:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    ref_mem[a] = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  // Raise mem_block and hold the request fields through the acceptance edge.
  task automatic issue(input logic wr, input logic [15:0] loc, input logic [15:0] data,
                       input bit track);
    if (track) model_op(wr, loc, data);
    mem_mode    = wr;
    mem_locator = loc;
    mem_write   = data;
    mem_block   = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_block = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (mem_response) seen = 1'b1;
    end
    check("resp_timeout", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic cpu_op(input logic wr, input logic [15:0] loc, input logic [15:0] data);
    issue(wr, loc, data, 1'b1);
    wait_done();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r2, f2, r1, f1;
    logic [15:0] d, keep;
    logic [7:0]  a;
    mem_block = 0; mem_mode = 0; mem_locator = 0; mem_write = 0;
    load_en = 0; load_addr = 0; load_data = 0;

    #1 rst_n = 1'b0;
    #20;
    check("rst_resp", {31'd0, mem_response}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_read", {16'd0, mem_read}, 32'd0);
    check("rst_fault", {31'd0, addr_fault}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 256; i++) do_load(8'(i), 16'($urandom));

    // Write then read back.
    cpu_op(1'b1, 16'h0010, 16'hBEEF);
    cpu_op(1'b0, 16'h0010, 16'h0000);
    check("beef_read", {16'd0, mem_read}, 32'h0000BEEF);

    // Latency: edge N is the first edge seeing the rise; count edges after it.
    model_op(1'b0, 16'h0010, 16'h0);
    mem_mode = 1'b0; mem_locator = 16'h0010; mem_block = 1'b1;
    r2 = -1; f2 = -1; r1 = -1; f1 = -1;
    @(posedge clk);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i == 1) mem_block = 1'b0;
      if (mem_response && r2 < 0) r2 = i;
      if (!mem_response && r2 >= 0 && f2 < 0) f2 = i;
      if (resp1 && r1 < 0) r1 = i;
      if (!resp1 && r1 >= 0 && f1 < 0) f1 = i;
    end
    check("lat2_rise", r2, 32'd3);
    check("lat2_fall", f2, 32'd4);
    check("lat1_rise", r1, 32'd2);
    check("lat1_fall", f1, 32'd3);

    // Out-of-range accesses: write dropped, read returns zero, fault sticky.
    keep = ref_mem[0];
    cpu_op(1'b1, 16'h0100, 16'h1234);
    cpu_op(1'b0, 16'h0100, 16'h0000);
    check("oor_read", {16'd0, mem_read}, 32'd0);
    cpu_op(1'b0, 16'h0000, 16'h0000);
    check("oor_word0", {16'd0, mem_read}, {16'd0, keep});
    check("fault_sticky", {31'd0, addr_fault}, 32'd1);

    // Loader then CPU fetch.
    do_load(8'h00, 16'hF000);
    do_load(8'h01, 16'h0040);
    cpu_op(1'b0, 16'h0000, 16'h0000);
    check("fetch0", {16'd0, mem_read}, 32'h0000F000);
    cpu_op(1'b0, 16'h0001, 16'h0000);
    check("fetch1", {16'd0, mem_read}, 32'h00000040);

    // Loader strobe while a transaction is in WAIT must be ignored.
    issue(1'b0, 16'h0001, 16'h0000, 1'b1);
    load_en = 1'b1; load_addr = 8'h01; load_data = 16'hDEAD;
    @(posedge clk); #1;
    load_en = 1'b0;
    wait_done();
    cpu_op(1'b0, 16'h0001, 16'h0000);
    check("load_in_wait", {16'd0, mem_read}, 32'h00000040);

    // Collision: load and request rise together, load held three cycles.
    d = 16'($urandom);
    ref_mem[8'h30] = d;
    model_op(1'b0, 16'h0030, 16'h0);
    load_en = 1'b1; load_addr = 8'h30; load_data = d;
    mem_mode = 1'b0; mem_locator = 16'h0030; mem_block = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("coll_busy1", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("coll_busy2", {31'd0, busy}, 32'd0);
    load_en = 1'b0;
    @(posedge clk); #1;
    check("coll_accept", {31'd0, busy}, 32'd1);
    mem_block = 1'b0;
    wait_done();
    check("coll_data", {16'd0, mem_read}, {16'd0, d});

    // Reset during WAIT aborts the write and produces no response.
    keep = ref_mem[8'h20];
    issue(1'b1, 16'h0020, 16'hAAAA, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_resp", {31'd0, mem_response}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_read", {16'd0, mem_read}, 32'd0);
    check("mid_rst_fault", {31'd0, addr_fault}, 32'd0);
    ref_fault = 1'b0;
    last_read = 16'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    cpu_op(1'b0, 16'h0020, 16'h0000);
    check("rst_kept", {16'd0, mem_read}, {16'd0, keep});

    // Randomised mix of loads, reads and writes, some out of range.
    for (int n = 0; n < 80; n++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      a = 8'($urandom);
      d = 16'($urandom);
      if (sel < 2) begin
        do_load(a, d);
      end else if (sel == 2) begin
        cpu_op(1'($urandom), 16'($urandom_range(256, 65535)), d);
      end else begin
        cpu_op(1'($urandom), {8'h00, a}, d);
      end
    end

    repeat (5) @(posedge clk);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
